// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl
//   Frame-level controller for the serial pattern-detection path. It accepts
//   words over a valid/ready handshake and shifts each one out MSB first, one
//   bit per cycle, into an overlapping bit-pattern matcher. Match history
//   carries across word boundaries and is cleared at the end of each frame.
//   Matches are counted per frame with a saturating counter.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   cfg_we     configuration write strobe (honoured only in IDLE between frames)
//   cfg_pat    pattern; bit len-1 is compared against the oldest history bit
//   cfg_len    pattern length; 0 acts as 1, values above PAT_MAX clamp
//   in_valid   producer has a word
//   in_ready   controller can accept a word
//   in_data    word, shifted out MSB first
//   in_last    the word closes the frame
//   match      one-cycle pulse per detected match
//   match_cnt  saturating match count for the current or most recent frame
//   ovf        sticky: a match arrived while match_cnt was saturated
//   busy       a frame is in progress
//   done       one-cycle pulse at end of frame
//
// state | meaning
// IDLE  | waiting for a word, in_ready high
// SHIFT | feeding the latched word into the matcher, one bit per cycle
// DONE  | one-cycle end-of-frame pulse; history is cleared on exit
module seq_scan_ctrl #(
  parameter int WORD_W  = 8,
  parameter int PAT_MAX = 8,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [PAT_MAX-1:0] cfg_pat,
  input  logic [3:0]         cfg_len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_data,
  input  logic               in_last,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               ovf,
  output logic               busy,
  output logic               done
);

  localparam int LEN_W = $clog2(PAT_MAX + 1);
  localparam int BIT_W = $clog2(WORD_W);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state;
  logic [WORD_W-1:0]  sreg;
  logic               last_q;
  logic [BIT_W-1:0]   bitc;
  logic [PAT_MAX-1:0] hist;
  logic [PAT_MAX-1:0] hist_n;
  logic [PAT_MAX-1:0] cfg_pat_q;
  logic [PAT_MAX-1:0] len_mask;
  logic [LEN_W-1:0]   vcnt;
  logic [LEN_W-1:0]   vcnt_n;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   len_new;
  logic               hit;

  always_comb begin
    len_new = LEN_W'(cfg_len);
    if (cfg_len == 4'd0)
      len_new = LEN_W'(1);
    else if (int'(cfg_len) > PAT_MAX)
      len_new = LEN_W'(PAT_MAX);
  end

  // Match is judged on the history as it will be after this bit is taken.
  always_comb begin
    hist_n = {hist[PAT_MAX-2:0], sreg[WORD_W-1]};
    vcnt_n = (int'(vcnt) < PAT_MAX) ? vcnt + LEN_W'(1) : vcnt;
    len_mask = '0;
    for (int i = 0; i < PAT_MAX; i++)
      len_mask[i] = (i < int'(len));
    hit = (vcnt_n >= len) && (((hist_n ^ cfg_pat_q) & len_mask) == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      match     <= 1'b0;
      match_cnt <= '0;
      ovf       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sreg      <= '0;
      last_q    <= 1'b0;
      bitc      <= '0;
      hist      <= '0;
      vcnt      <= '0;
      cfg_pat_q <= PAT_MAX'(9);
      len       <= LEN_W'(4);
    end else begin
      match <= 1'b0;
      done  <= 1'b0;

      // Takes effect on the accept edge too, so that word already sees it.
      if (cfg_we && state == IDLE && !busy) begin
        cfg_pat_q <= cfg_pat;
        len       <= len_new;
      end

      case (state)
        IDLE: begin
          if (in_valid) begin
            sreg     <= in_data;
            last_q   <= in_last;
            bitc     <= BIT_W'(WORD_W - 1);
            state    <= SHIFT;
            in_ready <= 1'b0;
            if (!busy) begin
              busy      <= 1'b1;
              match_cnt <= '0;
              ovf       <= 1'b0;
            end
          end
        end
        SHIFT: begin
          sreg  <= sreg << 1;
          hist  <= hist_n;
          vcnt  <= vcnt_n;
          match <= hit;
          if (hit) begin
            if (match_cnt == '1)
              ovf <= 1'b1;
            else
              match_cnt <= match_cnt + CNT_W'(1);
          end
          if (bitc == '0) begin
            if (last_q) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= IDLE;
              in_ready <= 1'b1;
            end
          end else begin
            bitc <= bitc - BIT_W'(1);
          end
        end
        DONE: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
          hist     <= '0;
          vcnt     <= '0;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
module tb_seq_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       cfg_we;
  logic [7:0] cfg_pat;
  logic [3:0] cfg_len;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       match;
  logic [1:0] match_cnt;
  logic       ovf;
  logic       busy;
  logic       done;

  seq_scan_ctrl #(.WORD_W(8), .PAT_MAX(8), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .match(match), .match_cnt(match_cnt), .ovf(ovf), .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_acc = 0;
  int done_seen = 0;
  logic acc_pending = 1'b0;

  typedef struct {int due; logic val;} mev_t;
  typedef struct {int due; logic [1:0] cnt; logic ovf;} dev_t;
  mev_t mq[$];
  dev_t dq[$];

  // reference model state
  logic [7:0] mhist;
  int         mvcnt;
  logic [7:0] mpat;
  int         mlen;
  int         mcnt;
  logic       movf;
  logic       mbusy;

  task automatic model_clear();
    mq.delete();
    dq.delete();
    mhist = 8'h00; mvcnt = 0; mpat = 8'h09; mlen = 4;
    mcnt = 0; movf = 1'b0; mbusy = 1'b0;
  endtask

  // Expected per-bit match pulses and end-of-frame results for an accepted word.
  task automatic model_accept(input logic [7:0] d, input logic last, input int a);
    logic h;
    mev_t e;
    dev_t f;
    if (!mbusy) begin
      mcnt = 0; movf = 1'b0; mbusy = 1'b1;
    end
    for (int k = 1; k <= 8; k++) begin
      mhist = {mhist[6:0], d[8-k]};
      if (mvcnt < 8) mvcnt++;
      h = (mvcnt >= mlen);
      for (int i = 0; i < mlen; i++)
        if (mhist[i] != mpat[i]) h = 1'b0;
      e.due = a + k; e.val = h;
      mq.push_back(e);
      if (h) begin
        if (mcnt == 3) movf = 1'b1;
        else mcnt++;
      end
    end
    if (last) begin
      f.due = a + 8; f.cnt = 2'(mcnt); f.ovf = movf;
      dq.push_back(f);
      mhist = 8'h00; mvcnt = 0; mbusy = 1'b0;
    end
  endtask

  always @(negedge clk) acc_pending = rst && in_valid && in_ready;

  always @(posedge clk) begin
    cyc++;
    if (acc_pending) begin
      last_acc = cyc;
      model_accept(in_data, in_last, cyc);
      acc_pending = 1'b0;
    end
  end

  // Scoreboard: match and done are compared every cycle against the queues.
  always @(negedge clk) begin
    logic em;
    logic ed;
    if (rst) begin
      em = 1'b0;
      if (mq.size() > 0 && mq[0].due == cyc) begin
        em = mq[0].val;
        void'(mq.pop_front());
      end
      checks++;
      if (match !== em) begin
        failures++;
        $display("FAIL match cyc=%0d got=%b exp=%b", cyc, match, em);
      end
      ed = (dq.size() > 0 && dq[0].due == cyc);
      checks++;
      if (done !== ed) begin
        failures++;
        $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done, ed);
      end
      if (done) done_seen++;
      if (ed) begin
        checks++;
        if (match_cnt !== dq[0].cnt || ovf !== dq[0].ovf) begin
          failures++;
          $display("FAIL frame_result cnt=%0d ovf=%b exp_cnt=%0d exp_ovf=%b",
                   match_cnt, ovf, dq[0].cnt, dq[0].ovf);
        end
        void'(dq.pop_front());
      end
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    bit got;
    in_data = d; in_last = last; in_valid = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin got = 1'b1; break; end
    end
    if (!got) begin
      failures++; checks++;
      $display("FAIL accept_timeout got=0 exp=1");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_frame();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (mq.size() == 0 && dq.size() == 0) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL frame_timeout got=pending exp=drained");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [7:0] p, input logic [3:0] l);
    cfg_we = 1'b1; cfg_pat = p; cfg_len = l;
    @(posedge clk);
    #1 cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || match_cnt !== 2'd0 || ovf !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_values rdy=%b busy=%b cnt=%0d ovf=%b done=%b exp=1,0,0,0,0",
               in_ready, busy, match_cnt, ovf, done);
    end
    send(8'h92, 1'b1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
    #2;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || match_cnt !== 2'd0 || ovf !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL midframe_reset rdy=%b busy=%b cnt=%0d ovf=%b done=%b exp=1,0,0,0,0",
               in_ready, busy, match_cnt, ovf, done);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    done_seen = 0;
    repeat (12) @(negedge clk);
    checks++;
    if (done_seen != 0) begin
      failures++;
      $display("FAIL reset_no_done got=%0d exp=0", done_seen);
    end
    @(posedge clk); #1;
    send(8'h90, 1'b1);
    wait_frame();
    checks++;
    if (match_cnt !== 2'd1) begin
      failures++;
      $display("FAIL after_reset_cnt got=%0d exp=1", match_cnt);
    end
  endtask

  task automatic test_default();
    int dcyc;
    send(8'h92, 1'b1);
    dcyc = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done) begin dcyc = cyc; break; end
    end
    checks++;
    if (dcyc - last_acc != 8) begin
      failures++;
      $display("FAIL done_latency got=%0d exp=8", dcyc - last_acc);
    end
    checks++;
    if (match_cnt !== 2'd2) begin
      failures++;
      $display("FAIL default_cnt got=%0d exp=2", match_cnt);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL post_done done=%b rdy=%b busy=%b exp=0,1,0", done, in_ready, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_cross_boundary();
    send(8'h02, 1'b0);
    send(8'h40, 1'b1);
    wait_frame();
    checks++;
    if (match_cnt !== 2'd1) begin
      failures++;
      $display("FAIL cross_cnt got=%0d exp=1", match_cnt);
    end
    send(8'h02, 1'b1);
    wait_frame();
    send(8'h40, 1'b1);
    wait_frame();
    checks++;
    if (match_cnt !== 2'd0) begin
      failures++;
      $display("FAIL split_frame_cnt got=%0d exp=0", match_cnt);
    end
  endtask

  task automatic test_saturation();
    cfg_write(8'h01, 4'd1);
    mpat = 8'h01; mlen = 1;
    send(8'hFF, 1'b1);
    wait_frame();
    checks++;
    if (match_cnt !== 2'd3 || ovf !== 1'b1) begin
      failures++;
      $display("FAIL saturate cnt=%0d ovf=%b exp=3,1", match_cnt, ovf);
    end
    send(8'h00, 1'b0);
    checks++;
    if (match_cnt !== 2'd0 || ovf !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL new_frame_clear cnt=%0d ovf=%b busy=%b exp=0,0,1", match_cnt, ovf, busy);
    end
    send(8'h00, 1'b1);
    wait_frame();
  endtask

  task automatic test_cfg_gating();
    cfg_write(8'h09, 4'd4);
    mpat = 8'h09; mlen = 4;
    send(8'h92, 1'b1);
    cfg_we = 1'b1; cfg_pat = 8'hFF; cfg_len = 4'd8;
    repeat (3) @(posedge clk);
    #1 cfg_we = 1'b0;
    wait_frame();
    checks++;
    if (match_cnt !== 2'd2) begin
      failures++;
      $display("FAIL cfg_ignored_cnt got=%0d exp=2", match_cnt);
    end
    cfg_write(8'hFF, 4'd8);
    mpat = 8'hFF; mlen = 8;
    send(8'hFF, 1'b1);
    wait_frame();
    checks++;
    if (match_cnt !== 2'd1) begin
      failures++;
      $display("FAIL cfg_applied_cnt got=%0d exp=1", match_cnt);
    end
    // length above PAT_MAX clamps to 8
    cfg_write(8'hFF, 4'd12);
    send(8'hFF, 1'b1);
    wait_frame();
    checks++;
    if (match_cnt !== 2'd1) begin
      failures++;
      $display("FAIL len_clamp_cnt got=%0d exp=1", match_cnt);
    end
    // length 0 acts as 1, written together with the accepted word
    cfg_we = 1'b1; cfg_pat = 8'h01; cfg_len = 4'd0;
    mpat = 8'h01; mlen = 1;
    send(8'h81, 1'b1);
    cfg_we = 1'b0;
    wait_frame();
    checks++;
    if (match_cnt !== 2'd2) begin
      failures++;
      $display("FAIL len_zero_cnt got=%0d exp=2", match_cnt);
    end
    cfg_write(8'h09, 4'd4);
    mpat = 8'h09; mlen = 4;
  endtask

  task automatic test_back_to_back();
    int acc[3];
    int busy_bad;
    logic [7:0] w[3];
    bit got;
    w[0] = 8'h92; w[1] = 8'h49; w[2] = 8'h24;
    busy_bad = 0;
    done_seen = 0;
    in_data = w[0]; in_last = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      got = 1'b0;
      for (int n = 0; n < 30; n++) begin
        @(negedge clk);
        if (k > 0 && busy !== 1'b1) busy_bad++;
        if (in_ready) begin got = 1'b1; break; end
      end
      if (!got) begin
        failures++; checks++;
        $display("FAIL b2b_accept_timeout word=%0d got=0 exp=1", k);
      end
      @(posedge clk);
      #1;
      acc[k] = last_acc;
      if (k == 0) begin in_data = w[1]; in_last = 1'b0; end
      else if (k == 1) begin in_data = w[2]; in_last = 1'b1; end
      else in_valid = 1'b0;
    end
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done) break;
      if (busy !== 1'b1) busy_bad++;
    end
    wait_frame();
    checks++;
    if (acc[1] - acc[0] != 9 || acc[2] - acc[1] != 9) begin
      failures++;
      $display("FAIL b2b_spacing got=%0d,%0d exp=9,9", acc[1] - acc[0], acc[2] - acc[1]);
    end
    checks++;
    if (busy_bad != 0) begin
      failures++;
      $display("FAIL b2b_busy low_cycles=%0d exp=0", busy_bad);
    end
    checks++;
    if (done_seen != 1) begin
      failures++;
      $display("FAIL b2b_done_pulses got=%0d exp=1", done_seen);
    end
  endtask

  initial begin
    rst = 1'b0; cfg_we = 1'b0; cfg_pat = 8'h00; cfg_len = 4'd0;
    in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    model_clear();
    test_reset();
    test_default();
    test_cross_boundary();
    test_saturation();
    test_cfg_gating();
    test_back_to_back();
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
